// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier: one conditional add plus right shift per
// clock through a single WIDTH_A-bit adder. Operands and product each use a
// valid/ready handshake, and the product is held until it is taken.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for an operand pair; in_ready high
// S_RUN  | one add/shift step per cycle, step counts 0..WIDTH_B-1
// S_HOLD | product valid; waits for out_ready (or abort)
module mult_seq_ctrl #(
   parameter int WIDTH_A = 8,
   parameter int WIDTH_B = 4,
   parameter int WIDTH_P = WIDTH_A + WIDTH_B
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH_A-1:0]             a,
   input  logic [WIDTH_B-1:0]             b,
   input  logic                           abort,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH_P-1:0]             product,
   output logic                           busy,
   output logic [$clog2(WIDTH_B+1)-1:0]   step
);

   localparam int SW = $clog2(WIDTH_B + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [WIDTH_A-1:0]  a_q;
   logic [WIDTH_B-1:0]  b_q;
   logic [WIDTH_P-1:0]  acc_q;
   logic [WIDTH_P-1:0]  acc_d;
   logic [SW-1:0]       step_q;
   logic [WIDTH_A-1:0]  addend;
   logic [WIDTH_A:0]    hi;
   logic                accept;
   logic                last_step;

   assign accept    = (state_q == S_IDLE) && in_valid && !abort;
   assign last_step = (step_q == SW'(WIDTH_B - 1));

   // Upper half plus the conditional addend; the carry is kept so the
   // shifted result never loses the top bit.
   assign addend = b_q[0] ? a_q : '0;
   assign hi     = {1'b0, acc_q[WIDTH_P-1:WIDTH_B]} + {1'b0, addend};

   generate
      if (WIDTH_B > 1) begin : g_shift
         assign acc_d = {hi, acc_q[WIDTH_B-1:1]};
      end else begin : g_single
         assign acc_d = hi;
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode; abort outranks both the final step and out_ready
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_RUN;
         S_RUN:   if (abort) state_d = S_IDLE;
                  else if (last_step) state_d = S_HOLD;
         S_HOLD:  if (abort || out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded purely from state (no input-to-output paths)
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_HOLD);
      busy      = (state_q != S_IDLE);
      step      = (state_q == S_RUN) ? step_q : '0;
   end

   // Operand capture, add/shift datapath and product register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         step_q  <= '0;
         product <= '0;
      end else begin
         if (accept) begin
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
            step_q <= '0;
         end else if (state_q == S_RUN && !abort) begin
            acc_q  <= acc_d;
            b_q    <= b_q >> 1;
            step_q <= step_q + SW'(1);
            if (last_step) product <= acc_d;
         end
      end
   end

endmodule
